// File: rtl/raytracing_worker_multi_pkg.sv
// Shared widths, types and FSM encoding for the multi-pixel ray worker.
package raytracing_worker_multi_pkg;

   localparam int COORD_W = 12;
   localparam int COLOR_W = 12;
   localparam int PROD_W  = 4 * COORD_W + 6;

   typedef logic [COLOR_W-1:0] Color;

   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic signed [COORD_W-1:0] z;
      logic        [COORD_W-2:0] r;
      Color                      col;
   } SphereC;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_FETCH = 4'd1,
      S_LOAD  = 4'd2,
      S_MUL   = 4'd3,
      S_DISC  = 4'd4,
      S_SQRT  = 4'd5,
      S_CMP   = 4'd6,
      S_NEXT  = 4'd7,
      S_EMIT  = 4'd8,
      S_DONE  = 4'd9
   } state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/isqrt_iter.sv
// Iterative restoring integer square root: one root bit per busy cycle,
// done pulses for one cycle once the floor root is available on root_o.
module isqrt_iter #(
   parameter int  IN_B  = 54,
   localparam int OUT_B = (IN_B + 1) / 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [IN_B-1:0]  op_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [OUT_B-1:0] root_o
);
   localparam int XB = 2 * OUT_B;
   localparam int RB = OUT_B + 3;
   localparam int CW = $clog2(OUT_B + 1);

   logic [XB-1:0]    x_q, x_d;
   logic [RB-1:0]    rem_q, rem_d, rem_sh_s, trial_s;
   logic [OUT_B-1:0] root_q, root_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;

   // Next-state: bring down two operand bits, try subtracting 4*root+1.
   always_comb begin
      rem_sh_s = (rem_q << 2'd2) | RB'(x_q[XB-1 -: 2]);
      trial_s  = RB'({root_q, 2'b01});
      x_d      = x_q;
      rem_d    = rem_q;
      root_d   = root_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (start_i) begin
         x_d    = XB'(op_i);
         rem_d  = {RB{1'b0}};
         root_d = {OUT_B{1'b0}};
         cnt_d  = {CW{1'b0}};
         busy_d = 1'b1;
      end else if (busy_q) begin
         x_d   = x_q << 2'd2;
         cnt_d = cnt_q + CW'(1'b1);
         if (rem_sh_s >= trial_s) begin
            rem_d  = rem_sh_s - trial_s;
            root_d = {root_q[OUT_B-2:0], 1'b1};
         end else begin
            rem_d  = rem_sh_s;
            root_d = {root_q[OUT_B-2:0], 1'b0};
         end
         if (cnt_q == CW'(OUT_B - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q    <= {XB{1'b0}};
         rem_q  <= {RB{1'b0}};
         root_q <= {OUT_B{1'b0}};
         cnt_q  <= {CW{1'b0}};
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         rem_q  <= rem_d;
         root_q <= root_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign root_o = root_q;

endmodule

// File: rtl/raytracing_worker_multi.sv
// Ray worker: renders JOBS pixels of one scanline, scanning the sphere table per
// pixel and streaming out the colour of the nearest hit in front of the camera.
module raytracing_worker_multi
   import raytracing_worker_multi_pkg::*;
#(
   parameter int   JOBS      = 16,
   parameter int   STRIDE    = 8,
   parameter int   N_SPHERES = 4,
   parameter int   COORD_B   = COORD_W,
   parameter int   PZ        = 320,
   parameter Color BG_COLOR  = 12'h000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic signed [COORD_B-1:0]     pixel_start_x,
   input  logic signed [COORD_B-1:0]     pixel_y,
   output logic [idx_w(N_SPHERES)-1:0]   sphere_idx,
   input  SphereC                        sphere_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [COORD_B-1:0]     out_x,
   output Color                          out_color,
   output logic                          busy,
   output logic                          done
);
   localparam int W  = PROD_W;
   localparam int RB = (W + 1) / 2;
   localparam int SW = idx_w(N_SPHERES);
   localparam int JW = idx_w(JOBS);

   state_e                     state_q, state_d;
   logic [JW-1:0]              job_q, job_d;
   logic [SW-1:0]              sph_q, sph_d;
   logic signed [COORD_B-1:0]  px_q, px_d, py_q, py_d;
   SphereC                     sphere_q, sphere_d;
   logic signed [W-1:0]        a_q, a_d, b_q, b_d, c_q, c_d, near_q, near_d;
   logic                       near_vld_q, near_vld_d;
   Color                       near_col_q, near_col_d;
   logic                       out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
   logic signed [COORD_B-1:0]  out_x_q, out_x_d;
   Color                       out_color_q, out_color_d;

   logic signed [W-1:0] px_w, py_w, sx_w, sy_w, sz_w, r_w, pz_w;
   logic signed [W-1:0] a_s, dot_s, b_s, c_s, ac_s, disc_s, root_w, q_s;
   logic                hit_s, last_sph_s, last_job_s, sq_start_s, sq_busy_s, sq_done_s;
   logic [RB-1:0]       sq_root_s;

   // Quadratic terms; operands are widened first so nothing overflows W bits.
   always_comb begin
      px_w   = {{(W-COORD_B){px_q[COORD_B-1]}}, px_q};
      py_w   = {{(W-COORD_B){py_q[COORD_B-1]}}, py_q};
      sx_w   = {{(W-COORD_W){sphere_q.x[COORD_W-1]}}, sphere_q.x};
      sy_w   = {{(W-COORD_W){sphere_q.y[COORD_W-1]}}, sphere_q.y};
      sz_w   = {{(W-COORD_W){sphere_q.z[COORD_W-1]}}, sphere_q.z};
      r_w    = {{(W-COORD_W+1){1'b0}}, sphere_q.r};
      pz_w   = W'(PZ);
      a_s    = px_w * px_w + py_w * py_w + pz_w * pz_w;
      dot_s  = px_w * sx_w + py_w * sy_w + pz_w * sz_w;
      b_s    = dot_s <<< 1'd1;
      c_s    = sx_w * sx_w + sy_w * sy_w + sz_w * sz_w - r_w * r_w;
      ac_s   = a_q * c_q;
      disc_s = b_q * b_q - (ac_s <<< 2'd2);
      root_w = {{(W-RB){1'b0}}, sq_root_s};
      q_s    = b_q - root_w;
      hit_s  = !q_s[W-1] && (q_s != {W{1'b0}}) && (!near_vld_q || (q_s < near_q));
      last_sph_s = (sph_q == SW'(N_SPHERES - 1));
      last_job_s = (job_q == JW'(JOBS - 1));
      sq_start_s = (state_q == S_DISC) && !disc_s[W-1];
   end

   isqrt_iter #(.IN_B(W)) u_isqrt (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (sq_start_s),
      .op_i    (disc_s),
      .busy_o  (sq_busy_s),
      .done_o  (sq_done_s),
      .root_o  (sq_root_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
         S_FETCH: state_d = S_LOAD;
         S_LOAD:  state_d = S_MUL;
         S_MUL:   state_d = S_DISC;
         S_DISC:  state_d = disc_s[W-1] ? S_NEXT : S_SQRT;
         S_SQRT:  state_d = (sq_done_s && !sq_busy_s) ? S_CMP : S_SQRT;
         S_CMP:   state_d = S_NEXT;
         S_NEXT:  state_d = last_sph_s ? S_EMIT : S_FETCH;
         S_EMIT: begin
            if (out_ready) begin
               state_d = last_job_s ? S_DONE : S_FETCH;
            end else begin
               state_d = S_EMIT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs and datapath next-state.
   always_comb begin
      job_d       = job_q;
      sph_d       = sph_q;
      px_d        = px_q;
      py_d        = py_q;
      sphere_d    = sphere_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      near_d      = near_q;
      near_vld_d  = near_vld_q;
      near_col_d  = near_col_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_color_d = out_color_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               px_d       = pixel_start_x;
               py_d       = pixel_y;
               job_d      = {JW{1'b0}};
               sph_d      = {SW{1'b0}};
               near_vld_d = 1'b0;
            end else begin
               px_d = px_q;
            end
         end
         S_LOAD: sphere_d = sphere_data;
         S_MUL: begin
            a_d = a_s;
            b_d = b_s;
            c_d = c_s;
         end
         S_CMP: begin
            if (hit_s) begin
               near_d     = q_s;
               near_vld_d = 1'b1;
               near_col_d = sphere_q.col;
            end else begin
               near_vld_d = near_vld_q;
            end
         end
         S_NEXT: begin
            if (last_sph_s) begin
               out_valid_d = 1'b1;
               out_x_d     = px_q;
               out_color_d = near_vld_q ? near_col_q : BG_COLOR;
            end else begin
               sph_d = sph_q + SW'(1'b1);
            end
         end
         S_EMIT: begin
            // Accepted pixel: step to the next one and clear the nearest-hit record.
            if (out_ready) begin
               out_valid_d = 1'b0;
               sph_d       = {SW{1'b0}};
               near_vld_d  = 1'b0;
               job_d       = job_q + JW'(1'b1);
               px_d        = px_q + COORD_B'(STRIDE);
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: out_valid_d = out_valid_q;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         job_q       <= {JW{1'b0}};
         sph_q       <= {SW{1'b0}};
         px_q        <= {COORD_B{1'b0}};
         py_q        <= {COORD_B{1'b0}};
         sphere_q    <= {$bits(SphereC){1'b0}};
         a_q         <= {W{1'b0}};
         b_q         <= {W{1'b0}};
         c_q         <= {W{1'b0}};
         near_q      <= {W{1'b0}};
         near_vld_q  <= 1'b0;
         near_col_q  <= BG_COLOR;
         out_valid_q <= 1'b0;
         out_x_q     <= {COORD_B{1'b0}};
         out_color_q <= BG_COLOR;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         job_q       <= job_d;
         sph_q       <= sph_d;
         px_q        <= px_d;
         py_q        <= py_d;
         sphere_q    <= sphere_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         near_q      <= near_d;
         near_vld_q  <= near_vld_d;
         near_col_q  <= near_col_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_color_q <= out_color_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign sphere_idx = sph_q;
   assign out_valid  = out_valid_q;
   assign out_x      = out_x_q;
   assign out_color  = out_color_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_raytracing_worker_multi.sv
// Directed bench: one single-pixel/single-sphere worker and one 4-pixel/2-sphere worker.
module tb_raytracing_worker_multi;
   import raytracing_worker_multi_pkg::*;

   localparam Color BG = 12'h123;

   logic clk, rst;
   int   n_cmp, n_err;

   logic              start_a, ov_a, or_a, busy_a, done_a;
   logic signed [11:0] psx_a, py_a, ox_a;
   logic [0:0]        idx_a;
   SphereC            sd_a;
   Color              oc_a;
   SphereC            mem_a [0:1];

   logic              start_b, ov_b, or_b, busy_b, done_b;
   logic signed [11:0] psx_b, py_b, ox_b;
   logic [0:0]        idx_b;
   SphereC            sd_b;
   Color              oc_b;
   SphereC            mem_b [0:1];

   logic signed [11:0] gx_b [4];
   Color               gc_b [4];
   int                 b_nout, b_unstable;

   raytracing_worker_multi #(.JOBS(1), .STRIDE(8), .N_SPHERES(1), .COORD_B(12), .PZ(320), .BG_COLOR(BG)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .pixel_start_x(psx_a), .pixel_y(py_a),
      .sphere_idx(idx_a), .sphere_data(sd_a), .out_valid(ov_a), .out_ready(or_a),
      .out_x(ox_a), .out_color(oc_a), .busy(busy_a), .done(done_a));

   raytracing_worker_multi #(.JOBS(4), .STRIDE(8), .N_SPHERES(2), .COORD_B(12), .PZ(320), .BG_COLOR(BG)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .pixel_start_x(psx_b), .pixel_y(py_b),
      .sphere_idx(idx_b), .sphere_data(sd_b), .out_valid(ov_b), .out_ready(or_b),
      .out_x(ox_b), .out_color(oc_b), .busy(busy_b), .done(done_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scene memory: data valid one cycle after the address.
   always @(posedge clk) begin
      sd_a <= mem_a[idx_a];
      sd_b <= mem_b[idx_b];
   end

   function automatic SphereC mk(input int x, input int y, input int z, input int r, input int col);
      SphereC s;
      s.x = 12'(x); s.y = 12'(y); s.z = 12'(z); s.r = 11'(r); s.col = 12'(col);
      return s;
   endfunction

   // Runs dut_a on pixel (0,0); lat counts cycles from start acceptance to out_valid.
   task automatic run_a(output int lat, output logic signed [11:0] gx, output Color gc, output bit to);
      to = 1'b0;
      @(negedge clk); start_a = 1'b1; psx_a = 12'sd0; py_a = 12'sd0;
      @(negedge clk); start_a = 1'b0;
      lat = 1;
      while (!ov_a && lat < 300) begin
         @(negedge clk); lat++;
      end
      to = !ov_a;
      gx = ox_a;
      gc = oc_a;
   endtask

   // Runs dut_b for 4 pixels, stalling each output; optionally pokes start while busy.
   task automatic run_b(input int sx, input int stall, input bit poke);
      int cyc;
      bit poked;
      logic signed [11:0] hx;
      Color hc;
      cyc = 0; poked = 1'b0; b_nout = 0; b_unstable = 0;
      or_b = 1'b0;
      @(negedge clk); start_b = 1'b1; psx_b = 12'(sx); py_b = 12'sd0;
      @(negedge clk); start_b = 1'b0;
      while (b_nout < 4 && cyc < 3000) begin
         if (ov_b) begin
            hx = ox_b; hc = oc_b;
            for (int k = 0; k < stall; k++) begin
               @(negedge clk); cyc++;
               if (ox_b !== hx || oc_b !== hc || ov_b !== 1'b1) b_unstable++;
            end
            gx_b[b_nout] = hx; gc_b[b_nout] = hc; b_nout++;
            or_b = 1'b1;
            @(negedge clk); cyc++;
            or_b = 1'b0;
         end else begin
            if (poke && !poked && b_nout == 1) begin
               start_b = 1'b1; psx_b = 12'sd100; poked = 1'b1;
            end
            @(negedge clk); cyc++;
            start_b = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ov_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || idx_a !== 1'b0 || ox_a !== 12'sd0 || oc_a !== BG) begin
         n_err++; $display("FAIL reset_a: got v=%b b=%b d=%b i=%b x=%0d c=%h want 0 0 0 0 0 %h", ov_a, busy_a, done_a, idx_a, ox_a, oc_a, BG);
      end
      n_cmp++;
      if (ov_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || idx_b !== 1'b0 || ox_b !== 12'sd0 || oc_b !== BG) begin
         n_err++; $display("FAIL reset_b: got v=%b b=%b d=%b i=%b x=%0d c=%h want 0 0 0 0 0 %h", ov_b, busy_b, done_b, idx_b, ox_b, oc_b, BG);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Sphere on axis at z=640: q = 409600 - isqrt(4096000000) = 345600 > 0.
   // Cost 4 + 28 (sqrt) + 2 cycles, out_valid on cycle 35.
   task automatic test_center_hit();
      int lat; logic signed [11:0] gx; Color gc; bit to;
      mem_a[0] = mk(0, 0, 640, 100, 12'hF00);
      run_a(lat, gx, gc, to);
      n_cmp++;
      if (to) begin n_err++; $display("FAIL center_timeout: got no out_valid want out_valid"); end
      n_cmp++;
      if (lat !== 35) begin n_err++; $display("FAIL center_latency: got %0d want 35", lat); end
      n_cmp++;
      if (gx !== 12'sd0 || gc !== 12'hF00) begin n_err++; $display("FAIL center_out: got x=%0d c=%h want x=0 c=f00", gx, gc); end
      @(negedge clk);
      n_cmp++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || ov_a !== 1'b0) begin
         n_err++; $display("FAIL center_done: got d=%b b=%b v=%b want 1 0 0", done_a, busy_a, ov_a);
      end
      @(negedge clk);
      n_cmp++;
      if (done_a !== 1'b0) begin n_err++; $display("FAIL center_done_pulse: got %b want 0", done_a); end
   endtask

   // Sphere behind camera: b = -409600, q < 0, background; sqrt still taken.
   task automatic test_behind();
      int lat; logic signed [11:0] gx; Color gc; bit to;
      mem_a[0] = mk(0, 0, -640, 100, 12'h0F0);
      run_a(lat, gx, gc, to);
      n_cmp++;
      if (to || lat !== 35 || gc !== BG) begin
         n_err++; $display("FAIL behind: got to=%b lat=%0d c=%h want 0 35 %h", to, lat, gc, BG);
      end
      repeat (2) @(negedge clk);
   endtask

   // Off-axis sphere: disc < 0, 5-cycle sphere, out_valid on cycle 6.
   task automatic test_disc_miss();
      int lat; logic signed [11:0] gx; Color gc; bit to;
      mem_a[0] = mk(2000, 0, 640, 10, 12'h00F);
      run_a(lat, gx, gc, to);
      n_cmp++;
      if (to || lat !== 6) begin n_err++; $display("FAIL discmiss_latency: got to=%b lat=%0d want 0 6", to, lat); end
      n_cmp++;
      if (gc !== BG) begin n_err++; $display("FAIL discmiss_color: got %h want %h", gc, BG); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_nearest();
      mem_b[0] = mk(0, 0, 640, 100, 12'hA0A);
      mem_b[1] = mk(0, 0, 1200, 100, 12'hB0B);
      run_b(0, 0, 1'b0);
      n_cmp++;
      if (b_nout !== 4) begin n_err++; $display("FAIL near_ab_count: got %0d want 4", b_nout); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (gc_b[i] !== 12'hA0A || gx_b[i] !== 12'(8 * i)) begin
            n_err++; $display("FAIL near_ab[%0d]: got x=%0d c=%h want x=%0d c=a0a", i, gx_b[i], gc_b[i], 8 * i);
         end
      end
      repeat (2) @(negedge clk);
      mem_b[0] = mk(0, 0, 1200, 100, 12'hB0B);
      mem_b[1] = mk(0, 0, 640, 100, 12'hA0A);
      run_b(0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (b_nout !== 4 || gc_b[i] !== 12'hA0A) begin
            n_err++; $display("FAIL near_ba[%0d]: got n=%0d c=%h want n=4 c=a0a", i, b_nout, gc_b[i]);
         end
      end
      repeat (2) @(negedge clk);
      mem_b[0] = mk(0, 0, 640, 100, 12'hC01);
      mem_b[1] = mk(0, 0, 640, 100, 12'hC02);
      run_b(0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (b_nout !== 4 || gc_b[i] !== 12'hC01) begin
            n_err++; $display("FAIL near_tie[%0d]: got n=%0d c=%h want n=4 c=c01", i, b_nout, gc_b[i]);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_backpressure();
      int exp_x [4] = '{-16, -8, 0, 8};
      int extra;
      mem_b[0] = mk(0, 0, 640, 100, 12'hA0A);
      mem_b[1] = mk(0, 0, 1200, 100, 12'hB0B);
      run_b(-16, 3, 1'b1);
      n_cmp++;
      if (b_nout !== 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", b_nout); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (gx_b[i] !== 12'(exp_x[i]) || gc_b[i] !== 12'hA0A) begin
            n_err++; $display("FAIL bp_x[%0d]: got x=%0d c=%h want x=%0d c=a0a", i, gx_b[i], gc_b[i], exp_x[i]);
         end
      end
      n_cmp++;
      if (b_unstable !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", b_unstable); end
      n_cmp++;
      if (done_b !== 1'b1 || busy_b !== 1'b0) begin n_err++; $display("FAIL bp_done: got d=%b b=%b want 1 0", done_b, busy_b); end
      extra = 0;
      or_b = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ov_b || busy_b) extra++;
      end
      or_b = 1'b0;
      n_cmp++;
      if (extra !== 0) begin n_err++; $display("FAIL bp_extra_start: got %0d busy/valid cycles want 0", extra); end
   endtask

   task automatic test_reset_mid_run();
      int cnt, xfers, extra;
      mem_b[0] = mk(0, 0, 640, 100, 12'hA0A);
      mem_b[1] = mk(0, 0, 1200, 100, 12'hB0B);
      or_b = 1'b1;
      @(negedge clk); start_b = 1'b1; psx_b = -12'sd16; py_b = 12'sd0;
      @(negedge clk); start_b = 1'b0;
      xfers = 0; cnt = 0;
      while (xfers < 2 && cnt < 2000) begin
         if (ov_b) xfers++;
         @(negedge clk); cnt++;
      end
      n_cmp++;
      if (xfers !== 2) begin n_err++; $display("FAIL rst_prefix: got %0d transfers want 2", xfers); end
      // Pixel 2 is in FETCH here; ten cycles later it is inside SQRT.
      repeat (10) @(negedge clk);
      n_cmp++;
      if (busy_b !== 1'b1 || ov_b !== 1'b0) begin n_err++; $display("FAIL rst_prestate: got b=%b v=%b want 1 0", busy_b, ov_b); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (ov_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || idx_b !== 1'b0 || ox_b !== 12'sd0 || oc_b !== BG) begin
         n_err++; $display("FAIL rst_mid_values: got v=%b b=%b d=%b i=%b x=%0d c=%h want 0 0 0 0 0 %h", ov_b, busy_b, done_b, idx_b, ox_b, oc_b, BG);
      end
      extra = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (ov_b || busy_b || done_b) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin n_err++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", extra); end
      run_b(40, 0, 1'b0);
      n_cmp++;
      if (b_nout !== 4 || gx_b[0] !== 12'sd40 || gx_b[3] !== 12'sd64 || gc_b[0] !== 12'hA0A) begin
         n_err++; $display("FAIL rst_restart: got n=%0d x0=%0d x3=%0d c0=%h want 4 40 64 a0a", b_nout, gx_b[0], gx_b[3], gc_b[0]);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b1;
      start_a = 1'b0; psx_a = 12'sd0; py_a = 12'sd0; or_a = 1'b1;
      start_b = 1'b0; psx_b = 12'sd0; py_b = 12'sd0; or_b = 1'b0;
      mem_a[0] = mk(0, 0, 640, 100, 12'hF00);
      mem_a[1] = mk(0, 0, 0, 0, 0);
      mem_b[0] = mk(0, 0, 640, 100, 12'hA0A);
      mem_b[1] = mk(0, 0, 1200, 100, 12'hB0B);
      test_reset();
      test_center_hit();
      test_behind();
      test_disc_miss();
      test_nearest();
      test_backpressure();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
